// File: rtl/frame_mapper.sv
// frame_mapper: transmit framer emitting NUM_ROWS x NUM_COLS frames of FAS0, FAS1, ARQ overhead, payload and CRC-8.
// Optional feature macro MAPPER_ERR_INJ_EN adds i_crc_err_inject to flip bit 0 of the transmitted CRC byte.
module frame_mapper #(
    parameter int         NUM_ROWS = 4,
    parameter int         NUM_COLS = 1024,
    parameter logic [7:0] FAS0     = 8'hF6,
    parameter logic [7:0] FAS1     = 8'h28
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [7:0] i_pyld_data,
    input  logic       i_pyld_data_valid,
    output logic       o_pyld_data_ready,
    input  logic       i_arq_en,
    input  logic       i_arq_en_valid,
`ifdef MAPPER_ERR_INJ_EN
    input  logic       i_crc_err_inject,
`endif
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas,
    input  logic       i_frame_data_ready,
    output logic [7:0] o_crc_val
);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] COL_PEN  = COL_W'(NUM_COLS - 2);

    typedef enum logic [2:0] {S_IDLE, S_FAS, S_OH, S_PYLD, S_CRC} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       crc_q, crc_d;
    logic             arq_q, arq_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fas_q, fas_d;
    logic [7:0]       crcval_q, crcval_d;
    logic             advance;
    logic             load;
    logic [7:0]       crc_byte;

    // CRC-8, polynomial 0x07, MSB first
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        state_d           = state_q;
        row_d             = row_q;
        col_d             = col_q;
        crc_d             = crc_q;
        arq_d             = arq_q;
        data_d            = data_q;
        valid_d           = valid_q;
        fas_d             = fas_q;
        crcval_d          = crcval_q;
        load              = 1'b0;
        o_pyld_data_ready = 1'b0;
        advance           = !valid_q || i_frame_data_ready;
        crc_byte          = crc_q;
`ifdef MAPPER_ERR_INJ_EN
        if (i_crc_err_inject) begin
            crc_byte[0] = ~crc_q[0];
        end
`endif

        if (advance) begin
            fas_d = 1'b0;
            case (state_q)
                S_IDLE: load = 1'b0;
                S_FAS: begin
                    load = 1'b1;
                    if (col_q == '0) begin
                        data_d = FAS0;
                        fas_d  = 1'b1;
                    end else begin
                        data_d  = FAS1;
                        state_d = S_OH;
                    end
                end
                S_OH: begin
                    load    = 1'b1;
                    data_d  = {7'b0, arq_q};
                    arq_d   = 1'b0;
                    state_d = S_PYLD;
                end
                S_PYLD: begin
                    o_pyld_data_ready = 1'b1;
                    if (i_pyld_data_valid) begin
                        load   = 1'b1;
                        data_d = i_pyld_data;
                        crc_d  = crc8_next(crc_q, i_pyld_data);
                        if (row_q == ROW_LAST && col_q == COL_PEN) begin
                            state_d = S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    load     = 1'b1;
                    data_d   = crc_byte;
                    crcval_d = crc_q;
                    crc_d    = 8'h00;
                    state_d  = i_enable ? S_FAS : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            valid_d = load;
        end

        if (state_q == S_IDLE && i_enable) begin
            state_d = S_FAS;
        end

        // A strobe landing on the OH load wins over the clear: it is meant for the next frame
        if (i_arq_en_valid) begin
            arq_d = i_arq_en;
        end

        if (load) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            crc_q    <= 8'h00;
            arq_q    <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            fas_q    <= 1'b0;
            crcval_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            crc_q    <= crc_d;
            arq_q    <= arq_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fas_q    <= fas_d;
            crcval_q <= crcval_d;
        end
    end

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = valid_q;
    assign o_frame_data_fas   = fas_q;
    assign o_crc_val          = crcval_q;

endmodule

// File: doc/frame_mapper.md
Name: frame_mapper

Overview:
- Transmit-side framer: pulls payload bytes from the client RX AXIS FIFO and builds fixed-size frames of NUM_ROWS x NUM_COLS bytes for the serial transmitter.
- Frame content, in transmit order: two FAS bytes, one ARQ overhead byte, payload bytes, and a trailing CRC-8 computed over the payload.
- It is the counterpart of the receive-side demapper; its frames must be accepted unmodified by that path.

Parameters:
- NUM_ROWS, 4, rows per frame; 2..4.
- NUM_COLS, 1024, bytes per row; 4..2047.
- FAS0, 8'hF6, first frame alignment byte.
- FAS1, 8'h28, second frame alignment byte.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  permits a new frame to start at a frame boundary
- i_pyld_data  in  8  client payload byte
- i_pyld_data_valid  in  1  client byte available
- o_pyld_data_ready  out  1  mapper accepts client byte this cycle
- i_arq_en  in  1  ARQ request value
- i_arq_en_valid  in  1  strobe qualifying i_arq_en
- o_frame_data  out  8  line byte to serial transmitter
- o_frame_data_valid  out  1  line byte valid
- o_frame_data_fas  out  1  marks FAS0 byte (row 0, col 0)
- i_frame_data_ready  in  1  serial transmitter accepts byte
- o_crc_val  out  8  CRC of last completed frame, for hardware display

Behaviour:
- Reset (async assert, sync release):
  - o_frame_data = 0, o_frame_data_valid = 0, o_frame_data_fas = 0, o_crc_val = 0, o_pyld_data_ready = 0.
  - FSM = IDLE, row/col counters = 0, CRC accumulator = 0, ARQ pending = 0.
- Output register load: loads when o_frame_data_valid = 0 or i_frame_data_ready = 1 ("advance").
  - Data and flags are held stable while valid = 1 and ready = 0.
  - Latency from an accepted payload byte to o_frame_data is 1 cycle.
- Frame position:
  - Row/col counters increment only on advance with a byte loaded.
  - col wraps at NUM_COLS-1 and increments row; row wraps at NUM_ROWS-1.
- FSM states:
  - IDLE: valid drops to 0 on advance. If i_enable = 1, go to FAS.
  - FAS: loads FAS0 with fas = 1, then FAS1 with fas = 0 (cols 0, 1). Then go to OH.
  - OH: loads {7'b0, arq_pending} at col 2. Then go to PYLD.
  - PYLD: o_pyld_data_ready = advance (combinational from state and i_frame_data_ready).
    - On valid & ready: load i_pyld_data and update the CRC.
    - If i_pyld_data_valid = 0: load nothing, o_frame_data_valid = 0 (line gap), counters hold.
    - After the byte at row NUM_ROWS-1, col NUM_COLS-2, go to CRC.
  - CRC: loads the final CRC byte at the last position.
    - o_crc_val <= CRC on the same advance; accumulator clears.
    - Go to FAS if i_enable = 1, else IDLE.
- i_enable is sampled only at frame boundaries; deasserting it mid-frame completes the current frame.
- CRC rules:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no final XOR.
  - Covers payload bytes only; FAS, OH and CRC bytes are excluded.
- ARQ rules:
  - i_arq_en_valid = 1 captures i_arq_en into arq_pending.
  - arq_pending clears when the OH byte loads.
  - If a strobe coincides with the OH load: the old pending value is transmitted and the new value is stored for the next frame.
- Payload per frame = NUM_ROWS*NUM_COLS - 4 bytes.
- Reset mid-frame discards the frame.
  - The next frame starts again at FAS0; no partial CRC survives.

Optional Feature:
- Macro: MAPPER_ERR_INJ_EN.
- When defined:
  - Adds input i_crc_err_inject (1 bit), sampled when the CRC byte loads.
  - If set, the transmitted CRC byte has bit 0 inverted; o_crc_val still reports the true CRC.
  - Used to exercise the receiver CRC error / ARQ path in the demo.
- When undefined: port absent, CRC byte always correct.

Test Plan (NUM_ROWS=4, NUM_COLS=8 → 28 payload bytes/frame):
- Reset, then i_enable=1, FIFO supplies 0x00..0x1B, ready tied 1 -> line bytes are F6 (fas=1), 28, 00, 00..1B, then CRC = CRC-8(0x00..0x1B). o_crc_val equals that CRC after the last byte.
- Toggle i_frame_data_ready randomly -> o_frame_data / valid / fas stable while stalled. Byte sequence is identical to scenario 1.
- Remove i_pyld_data_valid for 5 cycles after payload byte 10 -> valid gap of 5 cycles, no bytes dropped or duplicated, CRC unchanged.
- ARQ strobe during frame N's payload with i_arq_en=1 -> frame N+1 OH byte = 0x01, frame N+2 OH byte = 0x00. A strobe coincident with the OH load defers to the next frame.
- i_enable deasserted at payload byte 5 -> frame completes with CRC, then valid=0 indefinitely. Re-enable -> the next frame starts with F6, fas=1.
- With MAPPER_ERR_INJ_EN, i_crc_err_inject=1 on an all-0x00 payload -> CRC byte = 0x01, o_crc_val = 0x00. Async reset asserted mid-payload -> all outputs 0 immediately.
